pc: RTL and testbench

Program counter for the picoMIPS processor core. Holds the 4-bit instruction address driven to the program memory and advances it by one on each clock when the decoder requests it. Also implements the input-wait handshake: at two fixed wait addresses the counter stalls until slide switch SW8 reaches the required level, so the program can pause for user input.

---
 rtl/pc.sv | 57 +++++
 tb/tb_pc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc.sv
// picoMIPS program counter: advances on the decoder's PCincr and stalls at two
// wait addresses until the synchronized SW8 reaches the level each one needs.
module pc #(
   parameter int                  PC_WIDTH     = 4,
   parameter logic [PC_WIDTH-1:0] LAST_ADDR    = 4'd15,
   parameter logic [PC_WIDTH-1:0] WAIT_ADDR_HI = 4'd1,
   parameter logic [PC_WIDTH-1:0] WAIT_ADDR_LO = 4'd3,
   parameter int                  SYNC_STAGES  = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                PCincr,
   input  logic                SW8,
   output logic [PC_WIDTH-1:0] PCout
);

   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sw8_s;
   logic                   stall;

   assign sw8_s  = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], SW8};

   // HI takes precedence when both wait addresses coincide.
   always_comb begin
      stall = 1'b0;
      if (pc_q == WAIT_ADDR_HI)
         stall = ~sw8_s;
      else if (pc_q == WAIT_ADDR_LO)
         stall = sw8_s;
   end

   // Any value at or above LAST_ADDR wraps to 0 on the next increment.
   always_comb begin
      pc_d = pc_q;
      if (PCincr && !stall) begin
         if (pc_q >= LAST_ADDR)
            pc_d = '0;
         else
            pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q   <= '0;
         sync_q <= '0;
      end else begin
         pc_q   <= pc_d;
         sync_q <= sync_d;
      end
   end

   assign PCout = pc_q;

endmodule

// File: tb/tb_pc.sv
// Scoreboard bench for pc: the driver pushes the expected PCout of each edge,
// a monitor pops and compares it after that edge.
module tb_pc;

   localparam int PW   = 4;
   localparam int LAST = 15;
   localparam int HI   = 1;
   localparam int LO   = 3;
   localparam int SYNC = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          PCincr = 1'b0;
   logic          SW8 = 1'b0;
   logic [PW-1:0] PCout;

   int checks = 0;
   int failures = 0;
   int mpc = 0;
   bit hist[$];
   int exp_q[$];

   pc #(
      .PC_WIDTH(PW), .LAST_ADDR(4'd15), .WAIT_ADDR_HI(4'd1),
      .WAIT_ADDR_LO(4'd3), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .PCincr(PCincr), .SW8(SW8), .PCout(PCout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mpc = 0;
      hist.delete();
      repeat (SYNC) hist.push_back(1'b0);
   endtask

   // Model: SW8 seen by the stall logic is the value sampled SYNC edges earlier.
   task automatic step(input bit incr, input bit sw, input bit rst);
      bit s, st;
      @(negedge clk);
      PCincr  = incr;
      SW8     = sw;
      reset_n = rst;
      if (!rst) model_reset();
      else begin
         s  = hist[0];
         st = (mpc == HI) ? !s : ((mpc == LO) ? s : 1'b0);
         if (incr && !st) mpc = (mpc + 1) % (LAST + 1);
         void'(hist.pop_front());
         hist.push_back(sw);
      end
      exp_q.push_back(mpc);
   endtask

   task automatic run_to(input int target);
      int n = 0;
      while (mpc != target && n < 60) begin
         step(1'b1, (mpc <= HI) ? 1'b1 : 1'b0, 1'b1);
         n++;
      end
      if (mpc != target) check("run_to_bound", mpc, target);
   endtask

   // Monitor: every expectation corresponds to the next rising edge.
   initial begin
      int prev = 0;
      int e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pcout", int'(PCout), e);
            checks++;
            if (!(PCout == prev || int'(PCout) == prev + 1 || PCout == 0)) begin
               failures++;
               $display("FAIL step_legal: got %0d after %0d", PCout, prev);
            end
            prev = int'(PCout);
         end
      end
   end

   initial begin
      model_reset();
      #1 check("reset_state", int'(PCout), 0);
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // async reset mid-count
      run_to(5);
      step(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      model_reset();
      #1 check("async_reset", int'(PCout), 0);
      repeat (3) step(1'b1, 1'b1, 1'b0);

      // hold at 7 with SW8 toggling
      run_to(7);
      for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b1);
      #6 check("hold7", int'(PCout), 7);

      // wait HI
      repeat (2) step(1'b0, 1'b0, 1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b1);
      #6 check("wait_hi_stuck", int'(PCout), 1);
      repeat (2) step(1'b1, 1'b1, 1'b1);
      #6 check("wait_hi_edge2", int'(PCout), 1);
      step(1'b1, 1'b1, 1'b1);
      #6 check("wait_hi_edge3", int'(PCout), 2);

      // wait LO
      repeat (5) step(1'b1, 1'b1, 1'b1);
      #6 check("wait_lo_stuck", int'(PCout), 3);
      repeat (2) step(1'b1, 1'b0, 1'b1);
      #6 check("wait_lo_edge2", int'(PCout), 3);
      step(1'b1, 1'b0, 1'b1);
      #6 check("wait_lo_edge3", int'(PCout), 4);

      // wrap 4..15 -> 0
      repeat (11) step(1'b1, 1'b0, 1'b1);
      #6 check("wrap_last", int'(PCout), 15);
      step(1'b1, 1'b0, 1'b1);
      #6 check("wrap_zero", int'(PCout), 0);

      // SW8 toggling every cycle from reset
      repeat (2) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) step(1'b1, i[0], 1'b1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 49) != 0);

      repeat (3) @(posedge clk);
      #2 check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
